// File: rtl/beamform_thresh_v4.sv
// beamform_thresh_v4: per-beam, two-level power threshold detector with
// double-buffered (shadow/active) thresholds and per-beam/per-level holdoff.
// Optional feature: define THRESH_READBACK_EN to add the registered
// thresh_rd_o port, which returns the active threshold pair at thresh_addr_i.
module beamform_thresh_v4 #(
  parameter int NBEAMS       = 48,
  parameter int PWR_BITS     = 18,
  parameter int HOLDOFF_BITS = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NBEAMS*PWR_BITS-1:0]   power_i,
  input  logic                         power_valid_i,
  input  logic [2*PWR_BITS-1:0]        thresh_dat_i,
  input  logic [$clog2(NBEAMS)-1:0]    thresh_addr_i,
  input  logic                         thresh_wr_i,
  input  logic                         thresh_update_i,
  input  logic [NBEAMS-1:0]            mask_i,
  input  logic [HOLDOFF_BITS-1:0]      holdoff_i,
  output logic [2*NBEAMS-1:0]          trigger_o,
  output logic [1:0]                   trig_any_o
`ifdef THRESH_READBACK_EN
  ,
  output logic [2*PWR_BITS-1:0]        thresh_rd_o
`endif
);

  localparam int ADDR_W = $clog2(NBEAMS);
  localparam int TW     = 2 * PWR_BITS;

  // Unregistered trigger decisions, indexed level*NBEAMS + beam
  logic [2*NBEAMS-1:0] fire;
  // Active thresholds of all beams, flattened for the readback mux
  logic [NBEAMS*TW-1:0] active_flat;

  logic [2*NBEAMS-1:0] trigger_q, trigger_d;
  logic [1:0]          trig_any_q, trig_any_d;

  genvar gi, gl;
  generate
    for (gi = 0; gi < NBEAMS; gi++) begin : gen_beam
      logic [TW-1:0] shadow_q, shadow_d;
      logic [TW-1:0] active_q, active_d;
      logic          wr_hit;

      // Addresses >= NBEAMS never match any beam, so such writes are dropped
      assign wr_hit = thresh_wr_i && (thresh_addr_i == ADDR_W'(gi));

      // Shadow takes writes; active copies the pre-write shadow on update
      always_comb begin
        shadow_d = wr_hit ? thresh_dat_i : shadow_q;
        active_d = thresh_update_i ? shadow_q : active_q;
      end

      // Threshold storage; all-ones at reset so nothing can exceed it
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          shadow_q <= '1;
          active_q <= '1;
        end else begin
          shadow_q <= shadow_d;
          active_q <= active_d;
        end
      end

      assign active_flat[gi*TW +: TW] = active_q;

      for (gl = 0; gl < 2; gl++) begin : gen_lvl
        logic [HOLDOFF_BITS-1:0] hold_q, hold_d;
        logic                    cand;

        assign cand = power_valid_i &&
                      (power_i[gi*PWR_BITS +: PWR_BITS] > active_q[gl*PWR_BITS +: PWR_BITS]);
        assign fire[gl*NBEAMS+gi] = cand && !mask_i[gi] && (hold_q == '0);

        // Holdoff: reload on a trigger, otherwise count down to zero every cycle
        always_comb begin
          hold_d = hold_q;
          if (fire[gl*NBEAMS+gi]) begin
            hold_d = holdoff_i;
          end else if (hold_q != '0) begin
            hold_d = hold_q - HOLDOFF_BITS'(1);
          end
        end

        // Holdoff counter register
        always_ff @(posedge clk_i) begin
          if (rst_i) begin
            hold_q <= '0;
          end else begin
            hold_q <= hold_d;
          end
        end
      end
    end
  endgenerate

  // Per-level summary of this cycle's trigger decisions
  always_comb begin
    trigger_d  = fire;
    trig_any_d = {|fire[2*NBEAMS-1:NBEAMS], |fire[NBEAMS-1:0]};
  end

  // Output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trigger_q  <= '0;
      trig_any_q <= '0;
    end else begin
      trigger_q  <= trigger_d;
      trig_any_q <= trig_any_d;
    end
  end

  assign trigger_o  = trigger_q;
  assign trig_any_o = trig_any_q;

`ifdef THRESH_READBACK_EN
  logic [TW-1:0] thresh_rd_q, thresh_rd_d;

  // Readback mux over active pairs; an out-of-range address selects nothing
  always_comb begin
    thresh_rd_d = '0;
    for (int i = 0; i < NBEAMS; i++) begin
      if (thresh_addr_i == ADDR_W'(i)) begin
        thresh_rd_d = active_flat[i*TW +: TW];
      end
    end
  end

  // Readback register, one cycle of latency
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      thresh_rd_q <= '0;
    end else begin
      thresh_rd_q <= thresh_rd_d;
    end
  end

  assign thresh_rd_o = thresh_rd_q;
`else
  // Without readback the flattened active vector only feeds nothing else;
  // consume it so the build stays warning-free.
  logic active_unused;
  assign active_unused = ^active_flat;
`endif

endmodule

// File: tb/tb_beamform_thresh_v4.sv
// Directed testbench for beamform_thresh_v4 (default build, no readback).
module tb_beamform_thresh_v4;
  localparam int NB = 48;
  localparam int P  = 18;
  localparam int HB = 4;
  localparam int AW = $clog2(NB);

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NB*P-1:0]   power_i;
  logic              power_valid_i;
  logic [2*P-1:0]    thresh_dat_i;
  logic [AW-1:0]     thresh_addr_i;
  logic              thresh_wr_i;
  logic              thresh_update_i;
  logic [NB-1:0]     mask_i;
  logic [HB-1:0]     holdoff_i;
  logic [2*NB-1:0]   trigger_o;
  logic [1:0]        trig_any_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*NB-1:0] exp_trig;
  logic [6:0] hold_pat;

  beamform_thresh_v4 #(.NBEAMS(NB), .PWR_BITS(P), .HOLDOFF_BITS(HB)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .power_i(power_i), .power_valid_i(power_valid_i),
    .thresh_dat_i(thresh_dat_i), .thresh_addr_i(thresh_addr_i), .thresh_wr_i(thresh_wr_i),
    .thresh_update_i(thresh_update_i), .mask_i(mask_i), .holdoff_i(holdoff_i),
    .trigger_o(trigger_o), .trig_any_o(trig_any_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [2*NB-1:0] got, input logic [2*NB-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Advance one clock; inputs are then driven / outputs sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_pow(input int b, input int v);
    power_i[b*P +: P] = P'(v);
  endtask

  // Write a shadow pair and, optionally, update active in the following cycle
  task automatic wr_pair(input int b, input int l1, input int l0, input bit upd);
    thresh_addr_i = AW'(b);
    thresh_dat_i  = {P'(l1), P'(l0)};
    thresh_wr_i   = 1'b1;
    tick();
    thresh_wr_i   = 1'b0;
    if (upd) begin
      thresh_update_i = 1'b1;
      tick();
      thresh_update_i = 1'b0;
    end
  endtask

  function automatic logic [2*NB-1:0] bits2(input int a, input int b);
    logic [2*NB-1:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    return v;
  endfunction

  initial begin
    rst_i = 1'b1; power_i = '0; power_valid_i = 1'b0; thresh_dat_i = '0;
    thresh_addr_i = '0; thresh_wr_i = 1'b0; thresh_update_i = 1'b0;
    mask_i = '0; holdoff_i = '0;
    #1;
    repeat (3) tick();
    chk("reset_trigger", trigger_o, '0);
    chk("reset_any", {94'd0, trig_any_o}, '0);

    // All-ones power never exceeds the all-ones reset thresholds
    rst_i = 1'b0;
    power_i = '1; power_valid_i = 1'b1;
    tick();
    chk("post_rst_cycle", trigger_o, '0);
    tick();
    chk("allones_no_trig", trigger_o, '0);
    power_valid_i = 1'b0; power_i = '0;
    tick();

    // Beam 5: L1=200, L0=100
    wr_pair(5, 200, 100, 1'b1);
    set_pow(5, 150); power_valid_i = 1'b1;
    tick();
    chk("b5_150", trigger_o, bits2(5, -1));
    chk("b5_150_any", {94'd0, trig_any_o}, 96'd1);
    set_pow(5, 100);
    tick();
    chk("b5_100_equal", trigger_o, '0);
    set_pow(5, 201);
    tick();
    chk("b5_201_both", trigger_o, bits2(5, 53));
    chk("b5_201_any", {94'd0, trig_any_o}, 96'd3);
    power_valid_i = 1'b0;
    tick();
    chk("invalid_clears", trigger_o, '0);
    power_i = '0;

    // Beam 3: shadow write only, then update
    wr_pair(3, 1000, 500, 1'b0);
    set_pow(3, 262142); power_valid_i = 1'b1;
    tick();
    chk("b3_no_update", trigger_o, '0);
    power_valid_i = 1'b0; thresh_update_i = 1'b1;
    tick();
    thresh_update_i = 1'b0; power_valid_i = 1'b1;
    tick();
    chk("b3_after_update", trigger_o, bits2(3, 51));
    power_valid_i = 1'b0; power_i = '0;
    tick();

    // Beam 0 with holdoff 3, changed to 0 mid-holdoff
    wr_pair(0, 262143, 10, 1'b1);
    holdoff_i = 4'd3; set_pow(0, 50); power_valid_i = 1'b1;
    hold_pat = 7'b1110001; // LSB = first cycle
    for (int k = 0; k < 7; k++) begin
      tick();
      if (k == 0) holdoff_i = 4'd0;
      chk($sformatf("holdoff_c%0d", k), {95'd0, trigger_o[0]}, {95'd0, hold_pat[k]});
    end
    power_valid_i = 1'b0; power_i = '0;
    tick();

    // Beam 7: write together with update keeps old active value
    wr_pair(7, 1000, 300, 1'b1);
    thresh_addr_i = AW'(7); thresh_dat_i = {P'(1000), P'(2000)};
    thresh_wr_i = 1'b1; thresh_update_i = 1'b1;
    tick();
    thresh_wr_i = 1'b0; thresh_update_i = 1'b0;
    set_pow(7, 500); power_valid_i = 1'b1;
    tick();
    chk("b7_old_active", trigger_o, bits2(7, -1));
    power_valid_i = 1'b0; thresh_update_i = 1'b1;
    tick();
    thresh_update_i = 1'b0; power_valid_i = 1'b1;
    tick();
    chk("b7_new_active", trigger_o, '0);
    set_pow(7, 1500);
    tick();
    chk("b7_1500_l1", trigger_o, bits2(55, -1));
    power_valid_i = 1'b0; power_i = '0;
    tick();

    // Beam 2 masked, then unmasked
    wr_pair(2, 1000, 100, 1'b1);
    mask_i[2] = 1'b1; set_pow(2, 500); power_valid_i = 1'b1;
    tick();
    chk("b2_masked", trigger_o, '0);
    tick();
    chk("b2_masked2", trigger_o, '0);
    mask_i[2] = 1'b0;
    tick();
    chk("b2_unmasked", trigger_o, bits2(2, -1));
    power_valid_i = 1'b0; power_i = '0;
    tick();

    // Reset wins over write/update/valid in the same cycle
    rst_i = 1'b1; thresh_addr_i = AW'(9); thresh_dat_i = '0;
    thresh_wr_i = 1'b1; thresh_update_i = 1'b1; set_pow(5, 150); power_valid_i = 1'b1;
    tick();
    chk("rst_priority", trigger_o, '0);
    rst_i = 1'b0; thresh_wr_i = 1'b0; thresh_update_i = 1'b0;
    tick();
    chk("rst_cleared_b5", trigger_o, '0);
    thresh_update_i = 1'b1; power_valid_i = 1'b0;
    tick();
    thresh_update_i = 1'b0; power_valid_i = 1'b1;
    set_pow(9, 100);
    tick();
    chk("rst_dropped_wr", trigger_o, '0);
    power_valid_i = 1'b0; power_i = '0;
    tick();

    // Out-of-range addresses are ignored
    wr_pair(48, 0, 0, 1'b1);
    wr_pair(63, 0, 0, 1'b1);
    power_i = '0;
    for (int b = 0; b < NB; b++) set_pow(b, 262142);
    power_valid_i = 1'b1;
    tick();
    chk("oob_write_ignored", trigger_o, '0);
    power_valid_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
